// File: rtl/fb_pkg.sv
// Shared types and defaults for the framebuffer memory arbiter.
// The arbiter FSM, default widths and the CPU write-buffer entry layout live here.
package fb_pkg;

    localparam int FB_ADDR_W     = 15;
    localparam int FB_DATA_W     = 8;
    localparam int FB_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } fb_state_e;

    typedef struct packed {
        logic [FB_ADDR_W-1:0] addr;
        logic [FB_DATA_W-1:0] data;
    } fb_wr_entry_t;

    function automatic int fb_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO buffering CPU framebuffer writes until a free RAM slot.
// Combinational read of the head entry; count/full/empty update on the push/pop edge.
module fb_wr_fifo #(
    parameter int WIDTH = 23,
    parameter int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_count  = r_count;
    assign o_rdata  = r_mem[r_rd_ptr];

    // A push into a full FIFO is legal only when the head leaves on the same edge.
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge Clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fb_mem_arbiter.sv
// Arbitrates the single-port framebuffer RAM between scanout reads (always first),
// a fill-clear sequencer and buffered CPU writes; one RAM operation per cycle.
module fb_mem_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W     = FB_ADDR_W,
    parameter int DATA_W     = FB_DATA_W,
    parameter int FIFO_DEPTH = FB_FIFO_DEPTH
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              WrReq,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    output logic              WrFull,
    output logic              Overflow,
    input  logic              RdReq,
    input  logic [ADDR_W-1:0] RdAddr,
    output logic              RdValid,
    output logic [DATA_W-1:0] RdData,
    input  logic              ClrReq,
    input  logic [DATA_W-1:0] ClrValue,
    output logic              ClrBusy,
    output logic [ADDR_W-1:0] MemAddr,
    output logic              MemWe,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData
);

    localparam int CNT_W = fb_cnt_w(FIFO_DEPTH);
    localparam int ENT_W = ADDR_W + DATA_W;

    fb_state_e         r_state;
    fb_state_e         w_state_next;
    logic [ADDR_W-1:0] r_clr_addr;
    logic [DATA_W-1:0] r_clr_value;
    logic [CNT_W-1:0]  r_drain_cnt;
    logic              r_rd_d1;
    logic              r_rd_d2;

    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CNT_W-1:0]  w_count;
    logic [CNT_W-1:0]  w_count_next;
    logic [ENT_W-1:0]  w_fifo_rdata;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic              w_clr_wr;
    logic              w_clr_last;

    fb_wr_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({WrAddr, WrData}),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_count)
    );

    assign WrFull  = w_fifo_full;
    assign ClrBusy = (r_state != IDLE);

    // r_drain_cnt counts only entries queued before the clear request, so
    // writes arriving during DRAIN wait behind the fill instead of landing before it.
    always_comb begin
        w_clr_wr     = !RdReq && (r_state == CLEAR);
        w_clr_last   = w_clr_wr && (&r_clr_addr);
        w_pop        = !RdReq && !w_fifo_empty &&
                       ((r_state == IDLE) || ((r_state == DRAIN) && (r_drain_cnt != '0)));
        w_push       = WrReq && (!w_fifo_full || w_pop);
        w_drop       = WrReq && !w_push;
        w_count_next = w_count;
        if (w_push && !w_pop) begin
            w_count_next = w_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = w_count - CNT_W'(1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (ClrReq) w_state_next = DRAIN;
            DRAIN:   if (r_drain_cnt == '0) w_state_next = CLEAR;
            CLEAR:   if (w_clr_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_clr_value <= '0;
            r_drain_cnt <= '0;
            r_clr_addr  <= '0;
        end else begin
            if ((r_state == IDLE) && ClrReq) begin
                r_clr_value <= ClrValue;
                r_drain_cnt <= w_count_next;
            end else if ((r_state == DRAIN) && w_pop) begin
                r_drain_cnt <= r_drain_cnt - CNT_W'(1);
            end
            if (r_state == DRAIN) begin
                r_clr_addr <= '0;
            end else if (w_clr_wr) begin
                r_clr_addr <= r_clr_addr + ADDR_W'(1);
            end
        end
    end

    // RAM port: MemAddr holds its last value in slots with no operation.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            MemAddr  <= '0;
            MemWe    <= 1'b0;
            MemWData <= '0;
        end else if (RdReq) begin
            MemAddr <= RdAddr;
            MemWe   <= 1'b0;
        end else if (w_clr_wr) begin
            MemAddr  <= r_clr_addr;
            MemWe    <= 1'b1;
            MemWData <= r_clr_value;
        end else if (w_pop) begin
            MemAddr  <= w_fifo_rdata[ENT_W-1:DATA_W];
            MemWe    <= 1'b1;
            MemWData <= w_fifo_rdata[DATA_W-1:0];
        end else begin
            MemWe <= 1'b0;
        end
    end

    // Address goes out on edge k, RAM answers after k+1, result registered at k+2.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_rd_d1  <= 1'b0;
            r_rd_d2  <= 1'b0;
            RdValid  <= 1'b0;
            RdData   <= '0;
            Overflow <= 1'b0;
        end else begin
            r_rd_d1 <= RdReq;
            r_rd_d2 <= r_rd_d1;
            RdValid <= r_rd_d2;
            if (r_rd_d2) begin
                RdData <= MemRData;
            end
            if (w_drop) begin
                Overflow <= 1'b1;
            end
        end
    end

endmodule
